ps2_uart_bridge: RTL and testbench
==================================

// Module: ps2_uart_bridge
// PURPOSE
//  Buffered bridge between the PS/2 host receiver and the UART transmitter.
//  - Queues scan codes in a FIFO, so bursts (e.g. E0 F0 xx break sequences) are not lost while the UART is busy.
//  - Sends each code as a raw byte, or as two uppercase hex ASCII chars plus an optional separator.
//  - Keeps sticky error/overflow status and a saturating drop counter for board LEDs or debug.
// PARAMETERS
//  DEPTH     16    FIFO entries; power of 2, >=2
//  HEX_MODE  0     0: raw byte per code; 1: two ASCII hex chars per code
//  SEP_EN    1     HEX_MODE=1 only: append SEP_CHAR after each code
//  SEP_CHAR  8'h20 separator byte (space)
//  CNT_W     8     width of drop_cnt
// PORTS
//  clk             in   1            system clock
//  rst             in   1            synchronous reset, active-high
//  in_valid        in   1            1-cycle pulse: scan code received from ps2_host
//  in_data         in   8            scan code, qualified by in_valid
//  in_parity_err   in   1            1-cycle pulse: parity error on current frame
//  in_frame_err    in   1            1-cycle pulse: start/stop framing error
//  clr_stat        in   1            clears sticky flags and drop_cnt
//  tx_valid        out  1            byte available to uart_tx
//  tx_data         out  8            byte to send; stable while tx_valid && !tx_ready
//  tx_ready        in   1            uart_tx accepts byte this cycle
//  fifo_level      out  $clog2(DEPTH)+1  current FIFO occupancy
//  overflow        out  1            sticky: a code was dropped
//  drop_cnt        out  CNT_W        dropped-code count, saturating at all-ones
//  parity_err_seen out  1            sticky parity error
//  frame_err_seen  out  1            sticky framing error
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, FSM=IDLE. Reset mid-transfer abandons the current code and the queue.
//  - Push rule: in_valid pushes in_data when level<DEPTH, or when a pop happens in the same cycle.
//  - Drop rule: otherwise the code is dropped; overflow<=1 and drop_cnt increments unless saturated.
//  - Errored frames: in_data is still queued when in_valid=1. Error pulses only set their sticky flags.
//  - clr_stat: clears overflow, drop_cnt and both sticky flags. If an event occurs in the same cycle, the event wins:
//    flag=1 and drop_cnt=1.
//  - Handshake: a beat completes when tx_valid && tx_ready.
//    tx_valid, once high, stays high with tx_data stable until the beat completes.
//    tx_valid is registered (no combinational path from tx_ready).
//  - FSM states: IDLE, RAW, HI, LO, SEP.
//    IDLE: if FIFO non-empty, pop into cur_code and assert tx_valid next cycle.
//      Next state is RAW (HEX_MODE=0) or HI (HEX_MODE=1).
//    RAW:  tx_data=cur_code. On beat -> IDLE.
//    HI:   tx_data=ascii(cur_code[7:4]). On beat -> LO.
//    LO:   tx_data=ascii(cur_code[3:0]). On beat -> SEP if SEP_EN, else IDLE.
//    SEP:  tx_data=SEP_CHAR. On beat -> IDLE.
//    ascii(n) = n<10 ? 8'h30+n : 8'h37+n  ('A'..'F').
//  - Latency: in_valid at cycle N with FIFO empty and FSM idle gives tx_valid at N+2. IDLE costs one cycle per code.
//  - fifo_level: updates the cycle after push/pop. Simultaneous push+pop leaves the level unchanged.
//    Pointers wrap modulo DEPTH.
//  - Back-to-back in_valid pulses (illegal from ps2_host, tolerated here) each push or drop independently.
// STRUCTURE
//  - ps2_uart_pkg holds:
//    state_t enum {IDLE,RAW,HI,LO,SEP}; ASCII_0=8'h30 and ASCII_A_OFF=8'h37; function hex_nibble_to_ascii.
//  - Sub-module sync_fifo #(WIDTH=8, DEPTH): push/pop/full/empty/level, registered read data, no bypass.
//  - The bridge itself holds the FSM, cur_code, status registers and the tx output registers.
// TESTING
//  1 HEX_MODE=0: push 8'h1C with tx_ready=1 -> tx_valid at N+2, tx_data=8'h1C, one beat, then idle.
//  2 HEX_MODE=1, SEP_EN=1: push 8'hF0, tx_ready=1 -> beats 8'h46, 8'h30, 8'h20 in order.
//  3 DEPTH=4, tx_ready=0: push 6 codes -> fifo_level=4 after the first pop, overflow=1, drop_cnt=1.
//    Release tx_ready -> codes 1..5 are sent in order.
//  4 Hold tx_ready=0 for 10 cycles mid-code -> tx_valid and tx_data stay constant; no beat is lost or duplicated.
//  5 Pulse in_parity_err and clr_stat in the same cycle -> parity_err_seen=1.
//    clr_stat alone next cycle -> 0. Force drop_cnt to saturate -> it holds at 8'hFF.
//  6 Assert rst while state=LO with 3 codes queued -> next cycle tx_valid=0, fifo_level=0.
//    A new code afterwards is sent normally.

Source files
------------

// File: rtl/ps2_uart_pkg.sv
// ps2_uart_pkg: FSM states and hex-ASCII helper shared by the PS/2-to-UART bridge
package ps2_uart_pkg;
  typedef enum logic [2:0] {IDLE, RAW, HI, LO, SEP} state_t;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_A_OFF = 8'h37;
  function automatic logic [7:0] hex_nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10 ? ASCII_0 : ASCII_A_OFF) + {4'h0, n};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and no write-to-read bypass
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] level_q;
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      rd_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      level_q <= level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  assign rd_data = rd_data_q;
  assign full = level_q == FULL_LVL;
  assign empty = level_q == '0;
  assign level = level_q;
endmodule

// File: rtl/ps2_uart_bridge.sv
// ps2_uart_bridge: queues PS/2 scan codes and streams them to a UART as raw bytes or hex text,
// with sticky error/overflow flags and a saturating drop counter.
module ps2_uart_bridge
  import ps2_uart_pkg::*;
#(
  parameter int         DEPTH    = 16,
  parameter int         HEX_MODE = 0,
  parameter int         SEP_EN   = 1,
  parameter logic [7:0] SEP_CHAR = 8'h20,
  parameter int         CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   in_parity_err,
  input  logic                   in_frame_err,
  input  logic                   clr_stat,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   parity_err_seen,
  output logic                   frame_err_seen
);
  state_t state_q, state_d;
  logic push, pop, drop, beat, full, empty;
  logic [7:0] cur_code;
  logic tx_valid_q;
  logic overflow_q, overflow_d, par_q, par_d, frm_q, frm_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  // The FIFO read register is the current code: it only changes on a pop, which happens only in IDLE.
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .wr_data(in_data),
    .rd_data(cur_code), .full(full), .empty(empty), .level(fifo_level)
  );
  always_comb begin
    pop = state_q == IDLE && !empty;
    push = in_valid && (!full || pop);
    drop = in_valid && !push;
    beat = tx_valid_q && tx_ready;
    state_d = state_q == IDLE ? (pop ? (HEX_MODE != 0 ? HI : RAW) : IDLE) :
              !beat ? state_q :
              state_q == HI ? LO :
              (state_q == LO && SEP_EN != 0) ? SEP : IDLE;
    overflow_d = drop || (!clr_stat && overflow_q);
    par_d = in_parity_err || (!clr_stat && par_q);
    frm_d = in_frame_err || (!clr_stat && frm_q);
    drop_cnt_d = clr_stat ? CNT_W'(drop) : drop_cnt_q + CNT_W'(drop && !(&drop_cnt_q));
    tx_data = state_q == RAW ? cur_code :
              state_q == HI  ? hex_nibble_to_ascii(cur_code[7:4]) :
              state_q == LO  ? hex_nibble_to_ascii(cur_code[3:0]) :
              state_q == SEP ? SEP_CHAR : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      par_q <= 1'b0;
      frm_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      tx_valid_q <= state_d != IDLE;
      overflow_q <= overflow_d;
      par_q <= par_d;
      frm_q <= frm_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign tx_valid = tx_valid_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign parity_err_seen = par_q;
  assign frame_err_seen = frm_q;
endmodule

// File: tb/tb_ps2_uart_bridge.sv
// tb_ps2_uart_bridge: directed checks of a raw DEPTH=4 bridge (a_*) and a hex+separator bridge (b_*)
module tb_ps2_uart_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, par_err = 1'b0, frm_err = 1'b0, clr = 1'b0;
  logic a_in_valid = 1'b0, a_tx_ready = 1'b0, a_tx_valid, a_overflow, a_par, a_frm;
  logic [7:0] a_in_data = 8'h00, a_tx_data, a_drop;
  logic [2:0] a_level;
  logic b_in_valid = 1'b0, b_tx_ready = 1'b0, b_tx_valid, b_overflow, b_par, b_frm;
  logic [7:0] b_in_data = 8'h00, b_tx_data, b_drop;
  logic [4:0] b_level;
  int checks = 0, errors = 0;

  ps2_uart_bridge #(.DEPTH(4), .HEX_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_parity_err(par_err), .in_frame_err(frm_err), .clr_stat(clr),
    .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_ready(a_tx_ready),
    .fifo_level(a_level), .overflow(a_overflow), .drop_cnt(a_drop),
    .parity_err_seen(a_par), .frame_err_seen(a_frm)
  );
  ps2_uart_bridge #(.DEPTH(16), .HEX_MODE(1), .SEP_EN(1), .SEP_CHAR(8'h20)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_parity_err(par_err), .in_frame_err(frm_err), .clr_stat(clr),
    .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(b_tx_ready),
    .fifo_level(b_level), .overflow(b_overflow), .drop_cnt(b_drop),
    .parity_err_seen(b_par), .frame_err_seen(b_frm)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({a_tx_valid, a_tx_data, a_level, a_overflow, a_drop, a_par, a_frm} !== 22'h0) begin
      errors++;
      $display("FAIL reset_a got %h want 0", {a_tx_valid, a_tx_data, a_level, a_overflow, a_drop, a_par, a_frm});
    end
    checks++;
    if ({b_tx_valid, b_tx_data, b_level, b_overflow, b_drop, b_par, b_frm} !== 24'h0) begin
      errors++;
      $display("FAIL reset_b got %h want 0", {b_tx_valid, b_tx_data, b_level, b_overflow, b_drop, b_par, b_frm});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_raw_latency;
    a_tx_ready = 1'b1;
    a_in_data = 8'h1C;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    checks++;
    if (a_tx_valid !== 1'b0 || a_level !== 3'd1) begin
      errors++;
      $display("FAIL raw_n1 got valid=%b level=%0d want valid=0 level=1", a_tx_valid, a_level);
    end
    tick();
    checks++;
    if (a_tx_valid !== 1'b1 || a_tx_data !== 8'h1C || a_level !== 3'd0) begin
      errors++;
      $display("FAIL raw_n2 got valid=%b data=%h level=%0d want 1 1c 0", a_tx_valid, a_tx_data, a_level);
    end
    tick();
    checks++;
    if (a_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL raw_after_beat got valid=%b want 0", a_tx_valid);
    end
    tick();
    checks++;
    if (a_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL raw_idle got valid=%b want 0", a_tx_valid);
    end
  endtask

  task automatic test_hex;
    logic [7:0] exp [3];
    int k;
    exp = '{8'h46, 8'h30, 8'h20};
    k = 0;
    b_tx_ready = 1'b1;
    b_in_data = 8'hF0;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      if (b_tx_valid && b_tx_ready) begin
        checks++;
        if (k >= 3 || b_tx_data !== exp[k]) begin
          errors++;
          $display("FAIL hex_beat%0d got %h want %h", k, b_tx_data, k < 3 ? exp[k] : 8'hxx);
        end
        k++;
      end
      tick();
    end
    checks++;
    if (k != 3 || b_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL hex_count got beats=%0d valid=%b want 3 0", k, b_tx_valid);
    end
  endtask

  task automatic test_overflow;
    a_tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_in_data = 8'(8'h10 + i);
      a_in_valid = 1'b1;
      tick();
    end
    a_in_valid = 1'b0;
    checks++;
    if (a_level !== 3'd4 || a_overflow !== 1'b1 || a_drop !== 8'd1) begin
      errors++;
      $display("FAIL ovf_status got level=%0d ovf=%b drop=%0d want 4 1 1", a_level, a_overflow, a_drop);
    end
    checks++;
    if (a_tx_valid !== 1'b1 || a_tx_data !== 8'h10) begin
      errors++;
      $display("FAIL ovf_head got valid=%b data=%h want 1 10", a_tx_valid, a_tx_data);
    end
  endtask

  task automatic test_stall_and_drain;
    int k;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (a_tx_valid !== 1'b1 || a_tx_data !== 8'h10 || a_level !== 3'd4) begin
        errors++;
        $display("FAIL stall%0d got valid=%b data=%h level=%0d want 1 10 4", c, a_tx_valid, a_tx_data, a_level);
      end
    end
    a_tx_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      if (a_tx_valid && a_tx_ready) begin
        checks++;
        if (k >= 5 || a_tx_data !== 8'(8'h10 + k)) begin
          errors++;
          $display("FAIL drain_beat%0d got %h want %h", k, a_tx_data, 8'(8'h10 + k));
        end
        k++;
      end
      tick();
    end
    checks++;
    if (k != 5 || a_level !== 3'd0 || a_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_count got beats=%0d level=%0d valid=%b want 5 0 0", k, a_level, a_tx_valid);
    end
  endtask

  task automatic test_status;
    par_err = 1'b1;
    clr = 1'b1;
    tick();
    par_err = 1'b0;
    clr = 1'b0;
    checks++;
    if (a_par !== 1'b1 || a_overflow !== 1'b0 || a_drop !== 8'd0) begin
      errors++;
      $display("FAIL par_vs_clr got par=%b ovf=%b drop=%0d want 1 0 0", a_par, a_overflow, a_drop);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (a_par !== 1'b0) begin
      errors++;
      $display("FAIL par_clr got %b want 0", a_par);
    end
    frm_err = 1'b1;
    tick();
    frm_err = 1'b0;
    checks++;
    if (a_frm !== 1'b1 || a_par !== 1'b0) begin
      errors++;
      $display("FAIL frame_set got frm=%b par=%b want 1 0", a_frm, a_par);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    a_tx_ready = 1'b0;
    a_in_data = 8'h77;
    a_in_valid = 1'b1;
    repeat (260) tick();
    checks++;
    if (a_drop !== 8'hFF || a_overflow !== 1'b1 || a_frm !== 1'b0) begin
      errors++;
      $display("FAIL sat_reach got drop=%h ovf=%b frm=%b want ff 1 0", a_drop, a_overflow, a_frm);
    end
    tick();
    checks++;
    if (a_drop !== 8'hFF) begin
      errors++;
      $display("FAIL sat_hold got %h want ff", a_drop);
    end
    clr = 1'b1;
    tick();
    checks++;
    if (a_drop !== 8'd1 || a_overflow !== 1'b1) begin
      errors++;
      $display("FAIL drop_vs_clr got drop=%0d ovf=%b want 1 1", a_drop, a_overflow);
    end
    a_in_valid = 1'b0;
    tick();
    clr = 1'b0;
    checks++;
    if (a_drop !== 8'd0 || a_overflow !== 1'b0) begin
      errors++;
      $display("FAIL drop_clr got drop=%0d ovf=%b want 0 0", a_drop, a_overflow);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] codes [4];
    logic [7:0] exp [3];
    int k;
    codes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    exp = '{8'h35, 8'h41, 8'h20};
    b_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_in_data = codes[i];
      b_in_valid = 1'b1;
      tick();
    end
    b_in_valid = 1'b0;
    checks++;
    if (b_tx_valid !== 1'b1 || b_tx_data !== 8'h41 || b_level !== 5'd3) begin
      errors++;
      $display("FAIL mid_hi got valid=%b data=%h level=%0d want 1 41 3", b_tx_valid, b_tx_data, b_level);
    end
    b_tx_ready = 1'b1;
    tick();
    b_tx_ready = 1'b0;
    checks++;
    if (b_tx_valid !== 1'b1 || b_tx_data !== 8'h31) begin
      errors++;
      $display("FAIL mid_lo got valid=%b data=%h want 1 31", b_tx_valid, b_tx_data);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (b_tx_valid !== 1'b0 || b_level !== 5'd0 || b_tx_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_rst got valid=%b level=%0d data=%h want 0 0 00", b_tx_valid, b_level, b_tx_data);
    end
    rst = 1'b0;
    b_tx_ready = 1'b1;
    b_in_data = 8'h5A;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      if (b_tx_valid && b_tx_ready) begin
        checks++;
        if (k >= 3 || b_tx_data !== exp[k]) begin
          errors++;
          $display("FAIL post_rst_beat%0d got %h want %h", k, b_tx_data, k < 3 ? exp[k] : 8'hxx);
        end
        k++;
      end
      tick();
    end
    checks++;
    if (k != 3 || b_level !== 5'd0) begin
      errors++;
      $display("FAIL post_rst_count got beats=%0d level=%0d want 3 0", k, b_level);
    end
  endtask

  initial begin
    test_reset();
    test_raw_latency();
    test_hex();
    test_overflow();
    test_stall_and_drain();
    test_status();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
